shift_arb: RTL and testbench

- Shares one barrel-shift datapath (lsl, asr, ror) between two requesters, e.g. the CPU execute stage (port 0) and a graphics/DMA helper (port 1).
- Round-robin arbitration, valid/ready handshakes on both request ports and on the result port.
- Single-entry registered output stage.
- The block instantiates the existing lsl, asr and ror shifter modules and adds sequencing, selection and buffering around them.

---
 rtl/shift_arb.sv | 150 +++++++++++++++
 tb/tb_shift_arb.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_arb.sv
`default_nettype none
// ============================================================================
//  Module      : shift_arb (with helper shifters lsl, asr, ror)
//  Description : Two-port valid/ready arbiter sharing one 32-bit barrel-shift
//                datapath (lsl / asr / ror), with a single-entry registered
//                result stage. Round-robin or fixed-priority grant.
//                Build macro SHIFT_ARB_LSR_EN: when defined, op 2'b11 is a
//                logical shift right; otherwise op 2'b11 passes the operand
//                through unchanged.
//  Revision    : 1.0  initial release
// ============================================================================

// Logical shift left, zero fill.
module lsl (
  input  logic [31:0] value,
  input  logic [4:0]  shcnt,
  output logic [31:0] result
);
  assign result = value << shcnt;
endmodule

// Arithmetic shift right, sign fill.
module asr (
  input  logic [31:0] value,
  input  logic [4:0]  shcnt,
  output logic [31:0] result
);
  assign result = $unsigned($signed(value) >>> shcnt);
endmodule

// Rotate right. A left shift by 32 yields zero, so shcnt=0 returns value.
module ror (
  input  logic [31:0] value,
  input  logic [4:0]  shcnt,
  output logic [31:0] result
);
  assign result = (value >> shcnt) | (value << (6'd32 - {1'b0, shcnt}));
endmodule

module shift_arb #(
  parameter bit FIXED_PRIO = 1'b0   // 0: round-robin, 1: port 0 always wins
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [1:0]  req0_op,
  input  logic [31:0] req0_value,
  input  logic [4:0]  req0_shcnt,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [1:0]  req1_op,
  input  logic [31:0] req1_value,
  input  logic [4:0]  req1_shcnt,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic        res_id
);

  localparam logic [1:0] OP_LSL = 2'b00;
  localparam logic [1:0] OP_ASR = 2'b01;
  localparam logic [1:0] OP_ROR = 2'b10;

  logic        last_grant;
  logic        can_accept;
  logic        gnt_any;
  logic        gnt_sel;
  logic        accept;
  logic [1:0]  sel_op;
  logic [31:0] sel_value;
  logic [4:0]  sel_shcnt;
  logic [31:0] lsl_res;
  logic [31:0] asr_res;
  logic [31:0] ror_res;
  logic [31:0] op3_res;
  logic [31:0] shift_res;

  // Output slot is free when empty or being drained this cycle.
  assign can_accept = ~res_valid | res_ready;

  // Grant: a lone requester wins; on contention either alternate with the
  // last winner or favour port 0. gnt_sel is meaningless when gnt_any=0.
  always_comb begin
    gnt_any = req0_valid | req1_valid;
    gnt_sel = 1'b0;
    if (req0_valid && req1_valid) begin
      gnt_sel = FIXED_PRIO ? 1'b0 : ~last_grant;
    end else if (req1_valid) begin
      gnt_sel = 1'b1;
    end
  end

  // Readies depend only on state and valids, never on the requester's ready.
  assign req0_ready = can_accept & gnt_any & ~gnt_sel & ~rst;
  assign req1_ready = can_accept & gnt_any &  gnt_sel & ~rst;
  assign accept     = (req0_valid & req0_ready) | (req1_valid & req1_ready);

  // Steer the granted port's operands into the shared datapath.
  always_comb begin
    sel_op    = req0_op;
    sel_value = req0_value;
    sel_shcnt = req0_shcnt;
    if (gnt_sel) begin
      sel_op    = req1_op;
      sel_value = req1_value;
      sel_shcnt = req1_shcnt;
    end
  end

  lsl u_lsl (.value(sel_value), .shcnt(sel_shcnt), .result(lsl_res));
  asr u_asr (.value(sel_value), .shcnt(sel_shcnt), .result(asr_res));
  ror u_ror (.value(sel_value), .shcnt(sel_shcnt), .result(ror_res));

`ifdef SHIFT_ARB_LSR_EN
  assign op3_res = sel_value >> sel_shcnt;
`else
  assign op3_res = sel_value;
`endif

  // Pick the shifter output matching the selected opcode.
  always_comb begin
    case (sel_op)
      OP_LSL:  shift_res = lsl_res;
      OP_ASR:  shift_res = asr_res;
      OP_ROR:  shift_res = ror_res;
      default: shift_res = op3_res;
    endcase
  end

  // Result register and round-robin pointer; an accept overwrites the slot
  // even when it is being drained in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid  <= 1'b0;
      res_data   <= 32'd0;
      res_id     <= 1'b0;
      last_grant <= 1'b1;
    end else if (accept) begin
      res_valid  <= 1'b1;
      res_data   <= shift_res;
      res_id     <= gnt_sel;
      last_grant <= gnt_sel;
    end else if (res_ready) begin
      res_valid  <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_shift_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shift_arb
//  Description : Scoreboard bench for shift_arb. Per-port driver processes
//                present queued vectors; expected results are queued in
//                expected completion order and a monitor compares them.
//                A second instance checks FIXED_PRIO=1.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_shift_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [1:0]  req0_op, req1_op;
  logic [31:0] req0_value, req1_value;
  logic [4:0]  req0_shcnt, req1_shcnt;
  logic        res_valid, res_ready, res_id;
  logic [31:0] res_data;

  logic        fp_req0_valid, fp_req0_ready, fp_req1_valid, fp_req1_ready;
  logic        fp_res_valid, fp_res_ready, fp_res_id;
  logic [31:0] fp_res_data;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] value;
    logic [4:0]  shcnt;
  } vec_t;

  typedef struct {
    logic        id;
    logic [31:0] data;
  } exp_t;

  vec_t q0[$];
  vec_t q1[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  shift_arb #(.FIXED_PRIO(1'b0)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_value(req0_value), .req0_shcnt(req0_shcnt),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_value(req1_value), .req1_shcnt(req1_shcnt),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_id(res_id)
  );

  shift_arb #(.FIXED_PRIO(1'b1)) dut_fp (
    .clk(clk), .rst(rst),
    .req0_valid(fp_req0_valid), .req0_ready(fp_req0_ready), .req0_op(2'b00),
    .req0_value(32'h0000_0001), .req0_shcnt(5'd0),
    .req1_valid(fp_req1_valid), .req1_ready(fp_req1_ready), .req1_op(2'b00),
    .req1_value(32'h0000_0002), .req1_shcnt(5'd0),
    .res_valid(fp_res_valid), .res_ready(fp_res_ready), .res_data(fp_res_data),
    .res_id(fp_res_id)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  task automatic vec(input int port, input logic [1:0] op, input logic [31:0] value,
                     input logic [4:0] shcnt);
    vec_t v;
    v.op = op; v.value = value; v.shcnt = shcnt;
    if (port == 0) q0.push_back(v);
    else           q1.push_back(v);
  endtask

  task automatic expect_res(input logic id, input logic [31:0] data);
    exp_t e;
    e.id = id; e.data = data;
    sb.push_back(e);
  endtask

  task automatic wait_drain(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      done = (q0.size() == 0) && (q1.size() == 0) && (sb.size() == 0);
    end
    chk({name, "_outstanding"}, 32'(sb.size() + q0.size() + q1.size()), 32'd0);
    sb.delete(); q0.delete(); q1.delete();
  endtask

  // which: 0 = req0_valid, 1 = req1_valid, 2 = res_valid
  task automatic wait_high(input int which, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = (which == 0) ? req0_valid : (which == 1) ? req1_valid : res_valid;
    end
    chk({name, "_wait"}, 32'(seen), 32'd1);
  endtask

  // Port 0 driver: retire the head on a handshake, then present the next one.
  initial begin : drv0
    logic acc;
    req0_valid = 1'b0; req0_op = 2'b00; req0_value = 32'd0; req0_shcnt = 5'd0;
    forever begin
      @(negedge clk);
      acc = req0_valid & req0_ready;
      @(posedge clk);
      if (acc && q0.size() > 0) void'(q0.pop_front());
      #1;
      req0_valid = (q0.size() > 0);
      if (q0.size() > 0) begin
        req0_op = q0[0].op; req0_value = q0[0].value; req0_shcnt = q0[0].shcnt;
      end
    end
  end

  // Port 1 driver.
  initial begin : drv1
    logic acc;
    req1_valid = 1'b0; req1_op = 2'b00; req1_value = 32'd0; req1_shcnt = 5'd0;
    forever begin
      @(negedge clk);
      acc = req1_valid & req1_ready;
      @(posedge clk);
      if (acc && q1.size() > 0) void'(q1.pop_front());
      #1;
      req1_valid = (q1.size() > 0);
      if (q1.size() > 0) begin
        req1_op = q1[0].op; req1_value = q1[0].value; req1_shcnt = q1[0].shcnt;
      end
    end
  end

  // Monitor: every consumed result is compared against the scoreboard head.
  initial begin : mon
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && res_valid && res_ready) begin
        if (sb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_result: got id %0d data 0x%08h, required none", res_id, res_data);
        end else begin
          e = sb.pop_front();
          chk("res_id", 32'(res_id), 32'(e.id));
          chk("res_data", res_data, e.data);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

  initial begin : main
    rst = 1'b1; res_ready = 1'b1;
    fp_req0_valid = 1'b1; fp_req1_valid = 1'b1; fp_res_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_data", res_data, 32'd0);
    chk("rst_res_id", 32'(res_id), 32'd0);
    chk("rst_fp_req0_ready", 32'(fp_req0_ready), 32'd0);
    chk("rst_fp_req1_ready", 32'(fp_req1_ready), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Single lsl, ready in the presentation cycle, result one cycle later.
    @(negedge clk);
    vec(0, 2'b00, 32'h0000_0001, 5'd31); expect_res(1'b0, 32'h8000_0000);
    wait_high(0, "t1_valid");
    chk("t1_req0_ready", 32'(req0_ready), 32'd1);
    @(negedge clk);
    chk("t1_res_valid", 32'(res_valid), 32'd1);
    wait_drain("t1");

    // Port 1 asr then ror back-to-back.
    vec(1, 2'b01, 32'h8000_0000, 5'd4); expect_res(1'b1, 32'hF800_0000);
    vec(1, 2'b10, 32'h1234_5678, 5'd8); expect_res(1'b1, 32'h7812_3456);
    wait_high(1, "t2_valid");
    chk("t2_req1_ready", 32'(req1_ready), 32'd1);
    @(negedge clk);
    chk("t2_b2b_ready", 32'(req1_ready), 32'd1);
    chk("t2_b2b_valid", 32'(res_valid), 32'd1);
    wait_drain("t2");

    // Arithmetic corner cases on port 0.
    vec(0, 2'b00, 32'hFFFF_FFFF, 5'd4);  expect_res(1'b0, 32'hFFFF_FFF0);
    vec(0, 2'b01, 32'h7FFF_FFFF, 5'd4);  expect_res(1'b0, 32'h07FF_FFFF);
    vec(0, 2'b10, 32'h0000_0001, 5'd1);  expect_res(1'b0, 32'h8000_0000);
    vec(0, 2'b00, 32'hABCD_1234, 5'd0);  expect_res(1'b0, 32'hABCD_1234);
    vec(0, 2'b01, 32'h8000_0000, 5'd31); expect_res(1'b0, 32'hFFFF_FFFF);
    vec(0, 2'b10, 32'h8000_0001, 5'd0);  expect_res(1'b0, 32'h8000_0001);
    vec(0, 2'b01, 32'h8765_4321, 5'd0);  expect_res(1'b0, 32'h8765_4321);
    vec(0, 2'b00, 32'h8000_0001, 5'd1);  expect_res(1'b0, 32'h0000_0002);
    wait_drain("t3");

    // Contention, last winner was port 0: alternation starts with port 1.
    for (int k = 1; k <= 4; k++) begin
      vec(0, 2'b00, 32'h0000_0001, 5'(k));
      vec(1, 2'b10, 32'h0000_0001, 5'(k));
    end
    expect_res(1'b1, 32'h8000_0000); expect_res(1'b0, 32'h0000_0002);
    expect_res(1'b1, 32'h4000_0000); expect_res(1'b0, 32'h0000_0004);
    expect_res(1'b1, 32'h2000_0000); expect_res(1'b0, 32'h0000_0008);
    expect_res(1'b1, 32'h1000_0000); expect_res(1'b0, 32'h0000_0010);
    wait_drain("t4");

    // Lone port 1 win, idle gap, then contention resumes with port 0.
    vec(1, 2'b01, 32'hF000_0000, 5'd28); expect_res(1'b1, 32'hFFFF_FFFF);
    wait_drain("t5a");
    repeat (3) @(negedge clk);
    vec(0, 2'b00, 32'h0000_0003, 5'd2); vec(0, 2'b00, 32'h0000_0003, 5'd3);
    vec(1, 2'b10, 32'h0000_0003, 5'd1); vec(1, 2'b10, 32'h0000_0003, 5'd2);
    expect_res(1'b0, 32'h0000_000C); expect_res(1'b1, 32'h8000_0001);
    expect_res(1'b0, 32'h0000_0018); expect_res(1'b1, 32'hC000_0000);
    wait_drain("t5b");

    // Backpressure: held result, both requesters stalled, then drain+accept.
    @(posedge clk); #1 res_ready = 1'b0;
    @(negedge clk);
    vec(0, 2'b00, 32'h0000_0005, 5'd1);  vec(0, 2'b10, 32'h0000_000F, 5'd4);
    vec(1, 2'b01, 32'hF000_0000, 5'd8);  vec(1, 2'b00, 32'h0000_ABCD, 5'd16);
    expect_res(1'b0, 32'h0000_000A); expect_res(1'b1, 32'hFFF0_0000);
    expect_res(1'b0, 32'hF000_0000); expect_res(1'b1, 32'hABCD_0000);
    wait_high(2, "t6_first");
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("t6_stall_valids", {30'd0, req1_valid, req0_valid}, 32'd3);
      chk("t6_stall_readies", {30'd0, req1_ready, req0_ready}, 32'd0);
      chk("t6_stall_data", res_data, 32'h0000_000A);
    end
    @(posedge clk); #1 res_ready = 1'b1;
    @(negedge clk);
    chk("t6_release_req1_ready", 32'(req1_ready), 32'd1);
    @(negedge clk);
    chk("t6_release_res_valid", 32'(res_valid), 32'd1);
    wait_drain("t6");

    // Opcode 2'b11.
`ifdef SHIFT_ARB_LSR_EN
    vec(0, 2'b11, 32'h8000_0000, 5'd4); expect_res(1'b0, 32'h0800_0000);
`else
    vec(0, 2'b11, 32'h8000_0000, 5'd4); expect_res(1'b0, 32'h8000_0000);
`endif
    wait_drain("t7");

    // Reset mid-clock with a held result; port 0 was the last winner.
    @(posedge clk); #1 res_ready = 1'b0;
    @(negedge clk);
    vec(0, 2'b10, 32'h0000_0002, 5'd1);
    wait_high(2, "t8_held");
    @(posedge clk); #3 rst = 1'b1;
    #1;
    chk("t8_rst_res_valid", 32'(res_valid), 32'd0);
    chk("t8_rst_res_data", res_data, 32'd0);
    vec(0, 2'b00, 32'h0000_0001, 5'd8); vec(1, 2'b00, 32'h0000_0001, 5'd9);
    expect_res(1'b0, 32'h0000_0100); expect_res(1'b1, 32'h0000_0200);
    repeat (2) @(negedge clk);
    chk("t8_rst_readies", {30'd0, req1_ready, req0_ready}, 32'd0);
    @(posedge clk); #1 rst = 1'b0; res_ready = 1'b1;
    wait_drain("t8");

    // Fixed-priority instance: port 0 wins every cycle.
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("fp_res_valid", 32'(fp_res_valid), 32'd1);
      chk("fp_res_id", 32'(fp_res_id), 32'd0);
      chk("fp_res_data", fp_res_data, 32'h0000_0001);
      chk("fp_req1_ready", 32'(fp_req1_ready), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
